sensor_meas_scheduler: RTL

Sequences measurements on the ultrasonic and DHT sensor front-ends, allowing only one to run at a time. Request sources are the mode-routed button pulses (btn_ultra, btn_dht), the UART command decoder and a periodic auto-trigger. Each sensor has a start/done handshake, a per-sensor timeout and a minimum inter-measurement gap (DHT ≥ 2 s). Sits between the button/UART control layer and the sensor controllers; its result strobes drive UART report and FND update.

---
 rtl/sensor_sched_pkg.sv | 24 ++
 rtl/us_tick_gen.sv | 38 +++
 rtl/sensor_meas_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sensor_sched_pkg.sv
// Shared constants for the sensor measurement scheduler: FSM encoding,
// source identifiers and default microsecond timing values.
package sensor_sched_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Measurement source identifiers (also the encoding of active_src/result_src)
  localparam logic SRC_ULTRA = 1'b0;
  localparam logic SRC_DHT   = 1'b1;

  // Default timing, 100 MHz clock, all durations in microseconds
  localparam int DEF_TICK_CYC         = 100;
  localparam int DEF_ULTRA_TIMEOUT_US = 30000;
  localparam int DEF_DHT_TIMEOUT_US   = 30000;
  localparam int DEF_ULTRA_GAP_US     = 60000;
  localparam int DEF_DHT_GAP_US       = 2000000;
  localparam int DEF_AUTO_PERIOD_US   = 1000000;
  localparam int DEF_CNT_W            = 21;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler: one-clock tick pulse every TICK_CYC clocks.
module us_tick_gen
  import sensor_sched_pkg::*;
#(
  parameter int TICK_CYC = DEF_TICK_CYC
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            TW   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_CYC - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Wrap the prescaler and flag the last count of each period
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    tick_d = (cnt_q == LAST);
  end

  // Prescaler state, cleared by the active-low asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sensor_meas_scheduler.sv
// Serialises ultrasonic and DHT measurements: merges button/UART/auto
// requests, enforces per-sensor gaps and timeouts, and reports results.
module sensor_meas_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int TICK_CYC         = DEF_TICK_CYC,
  parameter int ULTRA_TIMEOUT_US = DEF_ULTRA_TIMEOUT_US,
  parameter int DHT_TIMEOUT_US   = DEF_DHT_TIMEOUT_US,
  parameter int ULTRA_GAP_US     = DEF_ULTRA_GAP_US,
  parameter int DHT_GAP_US       = DEF_DHT_GAP_US,
  parameter int AUTO_PERIOD_US   = DEF_AUTO_PERIOD_US,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ultra_btn,
  input  logic req_dht_btn,
  input  logic req_ultra_uart,
  input  logic req_dht_uart,
  input  logic auto_en,
  input  logic ultra_done,
  input  logic ultra_err,
  input  logic dht_done,
  input  logic dht_err,
  output logic ultra_start,
  output logic dht_start,
  output logic busy,
  output logic active_src,
  output logic result_valid,
  output logic result_fail,
  output logic result_src,
  output logic timeout_flag
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] U_TMO   = CNT_W'(ULTRA_TIMEOUT_US);
  localparam logic [CNT_W-1:0] D_TMO   = CNT_W'(DHT_TIMEOUT_US);
  localparam logic [CNT_W-1:0] U_GAP   = CNT_W'(ULTRA_GAP_US);
  localparam logic [CNT_W-1:0] D_GAP   = CNT_W'(DHT_GAP_US);
  localparam logic [CNT_W-1:0] AUTO_LD = CNT_W'(AUTO_PERIOD_US);

  logic tick;

  us_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0]       state_q, state_d;
  logic             active_src_q, active_src_d;
  logic             last_served_q, last_served_d;
  logic             pend_ultra_q, pend_ultra_d;
  logic             pend_dht_q, pend_dht_d;
  logic [CNT_W-1:0] gap_ultra_q, gap_ultra_d;
  logic [CNT_W-1:0] gap_dht_q, gap_dht_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] auto_q, auto_d;
  logic             ultra_start_q, ultra_start_d;
  logic             dht_start_q, dht_start_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic             result_fail_q, result_fail_d;
  logic             result_src_q, result_src_d;
  logic             timeout_flag_q, timeout_flag_d;

  logic auto_fire, elig_ultra, elig_dht, pick, act_done, act_err;

  // Next-state logic: counters, request merging, arbitration and the FSM.
  // Outputs are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_d        = state_q;
    active_src_d   = active_src_q;
    last_served_d  = last_served_q;
    pend_ultra_d   = pend_ultra_q;
    pend_dht_d     = pend_dht_q;
    gap_ultra_d    = gap_ultra_q;
    gap_dht_d      = gap_dht_q;
    tmo_d          = tmo_q;
    auto_d         = auto_q;
    ultra_start_d  = 1'b0;
    dht_start_d    = 1'b0;
    busy_d         = 1'b0;
    result_valid_d = 1'b0;
    result_fail_d  = 1'b0;
    result_src_d   = 1'b0;
    timeout_flag_d = 1'b0;
    auto_fire      = 1'b0;

    elig_ultra = pend_ultra_q && (gap_ultra_q == '0);
    elig_dht   = pend_dht_q && (gap_dht_q == '0);
    // On a tie, serve whichever sensor did not run last
    pick       = (elig_ultra && elig_dht) ? ~last_served_q : elig_dht;
    act_done   = (active_src_q == SRC_DHT) ? dht_done : ultra_done;
    act_err    = (active_src_q == SRC_DHT) ? dht_err  : ultra_err;

    // Gap counters free-run in every state and saturate at zero
    if (tick && (gap_ultra_q != '0)) gap_ultra_d = gap_ultra_q - CNT_ONE;
    if (tick && (gap_dht_q != '0))   gap_dht_d   = gap_dht_q - CNT_ONE;

    // Auto period: fire on the tick that takes the count to zero
    if (!auto_en) begin
      auto_d = AUTO_LD;
    end else if (tick) begin
      if (auto_q <= CNT_ONE) begin
        auto_fire = 1'b1;
        auto_d    = AUTO_LD;
      end else begin
        auto_d = auto_q - CNT_ONE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (elig_ultra || elig_dht) begin
          state_d      = ST_START;
          active_src_d = pick;
          busy_d       = 1'b1;
          if (pick == SRC_DHT) begin
            pend_dht_d  = 1'b0;
            dht_start_d = 1'b1;
          end else begin
            pend_ultra_d  = 1'b0;
            ultra_start_d = 1'b1;
          end
        end
      end
      ST_START: begin
        tmo_d   = (active_src_q == SRC_DHT) ? D_TMO : U_TMO;
        state_d = ST_WAIT;
        busy_d  = 1'b1;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        if (act_done) begin
          state_d        = ST_DONE;
          result_valid_d = 1'b1;
          result_src_d   = active_src_q;
        end else if (act_err) begin
          state_d       = ST_DONE;
          result_fail_d = 1'b1;
          result_src_d  = active_src_q;
        end else if (tmo_q == '0) begin
          state_d        = ST_DONE;
          result_fail_d  = 1'b1;
          timeout_flag_d = 1'b1;
          result_src_d   = active_src_q;
        end else if (tick) begin
          tmo_d = tmo_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d       = ST_IDLE;
        last_served_d = active_src_q;
        if (active_src_q == SRC_DHT) gap_dht_d   = D_GAP;
        else                         gap_ultra_d = U_GAP;
      end
      default: state_d = ST_IDLE;
    endcase

    // New requests win over the clear on START so a same-cycle request re-arms
    if (req_ultra_btn || req_ultra_uart || auto_fire) pend_ultra_d = 1'b1;
    if (req_dht_btn || req_dht_uart || auto_fire)     pend_dht_d   = 1'b1;
  end

  // Scheduler state and registered outputs, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      active_src_q   <= 1'b0;
      last_served_q  <= 1'b0;
      pend_ultra_q   <= 1'b0;
      pend_dht_q     <= 1'b0;
      gap_ultra_q    <= '0;
      gap_dht_q      <= '0;
      tmo_q          <= '0;
      auto_q         <= '0;
      ultra_start_q  <= 1'b0;
      dht_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_fail_q  <= 1'b0;
      result_src_q   <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_src_q   <= active_src_d;
      last_served_q  <= last_served_d;
      pend_ultra_q   <= pend_ultra_d;
      pend_dht_q     <= pend_dht_d;
      gap_ultra_q    <= gap_ultra_d;
      gap_dht_q      <= gap_dht_d;
      tmo_q          <= tmo_d;
      auto_q         <= auto_d;
      ultra_start_q  <= ultra_start_d;
      dht_start_q    <= dht_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_fail_q  <= result_fail_d;
      result_src_q   <= result_src_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign ultra_start  = ultra_start_q;
  assign dht_start    = dht_start_q;
  assign busy         = busy_q;
  assign active_src   = active_src_q;
  assign result_valid = result_valid_q;
  assign result_fail  = result_fail_q;
  assign result_src   = result_src_q;
  assign timeout_flag = timeout_flag_q;

endmodule
